// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
// The optional forwarding path is enabled by the HAZ_FWD_EN macro; see hazard_scoreboard.
package hazard_pkg;

    // Widest supported register address; narrower addresses are zero-extended.
    localparam int unsigned DST_W    = 8;
    // Entry index width: LAT is at most 8.
    localparam int unsigned K_W      = 3;
    localparam int unsigned FWD_NONE = 0;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             load;
        logic [DST_W-1:0] dst;
    } sb_entry_t;

    function automatic int unsigned sel_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/haz_match.sv
// Per-operand scoreboard lookup: finds the youngest in-flight writer of a source register.
// Register 0 and unused sources never match.
module haz_match
    import hazard_pkg::*;
#(
    parameter int unsigned LAT    = 3,
    parameter int unsigned REG_AW = 5
) (
    input  sb_entry_t          sb [LAT],
    input  logic [REG_AW-1:0]  src,
    input  logic               use_src,
    output logic               hit,
    output logic [K_W-1:0]     k,
    output logic               load
);

    always_comb begin
        hit  = 1'b0;
        k    = '0;
        load = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites earlier ones.
        for (int unsigned i = LAT; i > 0; i--) begin
            if (use_src && (src != '0) && sb[i-1].valid && sb[i-1].wr &&
                (sb[i-1].dst == DST_W'(src))) begin
                hit  = 1'b1;
                k    = K_W'(i - 1);
                load = sb[i-1].load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: stall on load-use, flush on redirect, registered EX selects.
// Define HAZ_FWD_EN for forwarding; otherwise every in-flight dependency stalls until retired.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LAT      = 3,
    parameter int unsigned LOAD_STG = 1,
    parameter int unsigned BR_STG   = 1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SEL_W    = sel_width(LAT)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush,
    output logic              id_byp_a,
    output logic              id_byp_b,
    output logic [SEL_W-1:0]  ex_fwd_a,
    output logic [SEL_W-1:0]  ex_fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [K_W-1:0] K_LOAD = K_W'(LOAD_STG);

    sb_entry_t          sb [LAT];
    sb_entry_t          new_entry;
    logic               hit_a, hit_b, load_a, load_b;
    logic [K_W-1:0]     k_a, k_b;
    logic               lu_a, lu_b, stall_req, issue;

    haz_match #(.LAT(LAT), .REG_AW(REG_AW)) u_match_a (
        .sb(sb), .src(id_rs), .use_src(id_valid & id_use_rs),
        .hit(hit_a), .k(k_a), .load(load_a)
    );

    haz_match #(.LAT(LAT), .REG_AW(REG_AW)) u_match_b (
        .sb(sb), .src(id_rt), .use_src(id_valid & id_use_rt),
        .hit(hit_b), .k(k_b), .load(load_b)
    );

    assign lu_a = hit_a && load_a && (k_a < K_LOAD);
    assign lu_b = hit_b && load_b && (k_b < K_LOAD);

`ifdef HAZ_FWD_EN
    localparam logic [K_W-1:0] K_LAST = K_W'(LAT - 1);

    logic [SEL_W-1:0] fwd_nxt_a, fwd_nxt_b;

    assign stall_req = lu_a || lu_b;
    assign id_byp_a  = hit_a && (k_a == K_LAST);
    assign id_byp_b  = hit_b && (k_b == K_LAST);
    assign fwd_nxt_a = (hit_a && (k_a != K_LAST)) ? SEL_W'(k_a + K_W'(1)) : SEL_W'(FWD_NONE);
    assign fwd_nxt_b = (hit_b && (k_b != K_LAST)) ? SEL_W'(k_b + K_W'(1)) : SEL_W'(FWD_NONE);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ex_fwd_a <= '0;
            ex_fwd_b <= '0;
        end else if (enable) begin
            ex_fwd_a <= issue ? fwd_nxt_a : '0;
            ex_fwd_b <= issue ? fwd_nxt_b : '0;
        end
    end
`else
    // Load-use terms are subsumed by any hit; kept so both builds share one stall path.
    assign stall_req = hit_a || hit_b || lu_a || lu_b;
    assign id_byp_a  = 1'b0;
    assign id_byp_b  = 1'b0;
    assign ex_fwd_a  = '0;
    assign ex_fwd_b  = '0;
`endif

    assign flush = br_taken;
    assign stall = stall_req && !br_taken;
    assign issue = id_valid && !stall && !br_taken;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = issue;
        new_entry.wr    = id_reg_write;
        new_entry.load  = id_mem_read;
        new_entry.dst   = DST_W'(id_dst);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                sb[i] <= '0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (enable) begin
            sb[0] <= issue ? new_entry : '0;
            // Entries younger than the resolving branch are squashed as they shift.
            for (int unsigned i = 1; i < LAT; i++) begin
                sb[i] <= sb[i-1];
                if (br_taken && ((i - 1) < BR_STG)) begin
                    sb[i].valid <= 1'b0;
                end
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the HAZ_FWD_EN build setting.
module tb_hazard_scoreboard;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst, enable;
    logic        id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, br_taken;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        stall, flush, id_byp_a, id_byp_b;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s2_valid, s2_use_rs, s2_use_rt, s2_reg_write, s2_mem_read;
    logic [4:0]  s2_rs, s2_rt, s2_dst;
    logic        s2_stall, s2_flush, s2_byp_a, s2_byp_b;
    logic [1:0]  s2_fwd_a, s2_fwd_b;
    logic [3:0]  s2_stall_cnt, s2_flush_cnt;

    hazard_scoreboard dut (
        .clk(clk), .arst(arst), .enable(enable), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .br_taken(br_taken), .stall(stall), .flush(flush),
        .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_scoreboard #(.CNT_W(4)) dut_sat (
        .clk(clk), .arst(arst), .enable(enable), .id_valid(s2_valid),
        .id_rs(s2_rs), .id_rt(s2_rt), .id_use_rs(s2_use_rs), .id_use_rt(s2_use_rt),
        .id_dst(s2_dst), .id_reg_write(s2_reg_write), .id_mem_read(s2_mem_read),
        .br_taken(1'b0), .stall(s2_stall), .flush(s2_flush),
        .id_byp_a(s2_byp_a), .id_byp_b(s2_byp_b), .ex_fwd_a(s2_fwd_a), .ex_fwd_b(s2_fwd_b),
        .stall_cnt(s2_stall_cnt), .flush_cnt(s2_flush_cnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       br;
        logic       e_stall;
        logic       e_flush;
        logic       e_byp_a;
        logic       e_byp_b;
        logic [1:0] e_fwd_a;
        logic [1:0] e_fwd_b;
    } vec_t;

    vec_t tv[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t ins(logic v, logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                                 logic [4:0] dst, logic rw, logic mr, logic br,
                                 logic es, logic ef, logic ba, logic bb,
                                 logic [1:0] fa, logic [1:0] fb);
        vec_t t;
        t.v = v; t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt;
        t.dst = dst; t.rw = rw; t.mr = mr; t.br = br;
        t.e_stall = es; t.e_flush = ef; t.e_byp_a = ba; t.e_byp_b = bb;
        t.e_fwd_a = fa; t.e_fwd_b = fb;
        return t;
    endfunction

    function automatic vec_t nop(logic [1:0] fa, logic [1:0] fb);
        return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_use_rs = t.urs; id_rt = t.rt; id_use_rt = t.urt;
        id_dst = t.dst; id_reg_write = t.rw; id_mem_read = t.mr; br_taken = t.br;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base_stall;
        bit          timed_out;

        arst = 1'b1; enable = 1'b1;
        drive(nop(0, 0));
        s2_valid = 0; s2_rs = 0; s2_rt = 0; s2_use_rs = 0; s2_use_rt = 0;
        s2_dst = 0; s2_reg_write = 0; s2_mem_read = 0;

`ifdef HAZ_FWD_EN
        tv.push_back(ins(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add $3,$1,$2
        tv.push_back(ins(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // sub $4,$3,$5
        tv.push_back(nop(1, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(ins(1, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // lw $3,0($0)
        tv.push_back(ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0)); // add $4,$3,$3 stalls
        tv.push_back(ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(nop(2, 2));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(ins(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // producer of $7
        tv.push_back(ins(1, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 7, 1, 2, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // consumer: bypass
        tv.push_back(nop(0, 0));
        tv.push_back(ins(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // write $0
        tv.push_back(ins(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // read $0
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(ins(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // lw $5
        tv.push_back(ins(1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 1, 0, 0, 0, 0)); // load-use + br_taken
        tv.push_back(ins(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        base_stall = 1;
`else
        tv.push_back(ins(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add $3,$1,$2
        tv.push_back(ins(1, 3, 1, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0)); // sub waits 3 cycles
        tv.push_back(ins(1, 3, 1, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 3, 1, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(ins(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // write $0
        tv.push_back(ins(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // read $0
        tv.push_back(ins(1, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // lw $3
        tv.push_back(ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(ins(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // lw $5
        tv.push_back(ins(1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 1, 0, 0, 0, 0)); // dependency + br_taken
        tv.push_back(ins(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        tv.push_back(nop(0, 0));
        base_stall = 6;
`endif

        @(negedge clk);
        check("reset stall", stall, 0);
        check("reset flush", flush, 0);
        check("reset byp", {id_byp_a, id_byp_b}, 0);
        check("reset fwd", {ex_fwd_a, ex_fwd_b}, 0);
        check("reset stall_cnt", stall_cnt, 0);
        check("reset flush_cnt", flush_cnt, 0);
        arst = 1'b0;
        next_cycle();

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #1;
            check($sformatf("v%0d stall", i), stall, tv[i].e_stall);
            check($sformatf("v%0d flush", i), flush, tv[i].e_flush);
            check($sformatf("v%0d byp_a", i), id_byp_a, tv[i].e_byp_a);
            check($sformatf("v%0d byp_b", i), id_byp_b, tv[i].e_byp_b);
            check($sformatf("v%0d fwd_a", i), ex_fwd_a, tv[i].e_fwd_a);
            check($sformatf("v%0d fwd_b", i), ex_fwd_b, tv[i].e_fwd_b);
            next_cycle();
        end
        check("table stall_cnt", stall_cnt, base_stall);
        check("table flush_cnt", flush_cnt, 1);

        // Freeze: a pending dependency is visible but nothing advances or counts.
        drive(ins(1, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        #1 check("en lw stall", stall, 0);
        next_cycle();
        enable = 1'b0;
        drive(ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 check("frozen stall 1", stall, 1);
        next_cycle();
        #1 check("frozen stall 2", stall, 1);
        next_cycle();
        check("frozen stall_cnt", stall_cnt, base_stall);
        enable = 1'b1;
        #1 check("resume stall", stall, 1);

        // Reset in the middle of the stall, then the held instruction issues.
        arst = 1'b1;
        #1;
        check("midreset stall", stall, 0);
        check("midreset stall_cnt", stall_cnt, 0);
        check("midreset flush_cnt", flush_cnt, 0);
        check("midreset fwd", {ex_fwd_a, ex_fwd_b}, 0);
        #1 arst = 1'b0;
        next_cycle();
        check("post-reset stall_cnt", stall_cnt, 0);
        drive(ins(1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 check("post-reset dep stall", stall, FWD ? 0 : 1);
        next_cycle();
        check("post-reset fwd_a", ex_fwd_a, FWD ? 1 : 0);
        check("post-reset stall_cnt2", stall_cnt, FWD ? 0 : 1);
        drive(nop(0, 0));
        repeat (4) next_cycle();

        // Saturation on the narrow-counter instance.
        timed_out = 1'b0;
        for (int it = 0; it < 20; it++) begin
            int guard;
            s2_valid = 1; s2_rs = 0; s2_use_rs = 1; s2_rt = 0; s2_use_rt = 0;
            s2_dst = 3; s2_reg_write = 1; s2_mem_read = 1;
            next_cycle();
            s2_rs = 3; s2_use_rs = 1; s2_rt = 3; s2_use_rt = 1; s2_dst = 4; s2_mem_read = 0;
            #1;
            guard = 0;
            while (s2_stall && guard < 10) begin
                next_cycle();
                #1;
                guard++;
            end
            if (guard >= 10) timed_out = 1'b1;
            next_cycle();
        end
        s2_valid = 0;
        check("sat stall bound", timed_out, 0);
        check("sat stall_cnt", s2_stall_cnt, 4'hF);
        check("sat flush_cnt", s2_flush_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
